// File: rtl/seq_comparator.sv
// Multi-cycle magnitude comparator: walks operands CHUNK bits per cycle from the MSB chunk down.
// Optional build macro COMPARATOR_EARLY_EXIT_EN ends the compare at the first differing chunk.
module seq_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             a_greater,
    output logic             b_greater,
    output logic             ab_equal
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0]  IDX_TOP   = IDXW'(NCHUNK - 1);
    localparam logic [IDXW-1:0]  IDX_ZERO  = {IDXW{1'b0}};
    localparam logic [IDXW-1:0]  IDX_ONE   = IDXW'(1);
    // Flipping the sign bit maps two's-complement ordering onto unsigned ordering.
    localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1'b1) << (WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] a_r, a_s, b_r, b_s;
    logic             sm_r, sm_s;
    logic [IDXW-1:0]  idx_r, idx_s;
    logic             decided_r, decided_s;
    logic             dir_r, dir_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             a_gt_r, a_gt_s, b_gt_r, b_gt_s, eq_r, eq_s;

    logic [WIDTH-1:0] a_x_s, b_x_s;
    logic [CHUNK-1:0] a_chunk_s, b_chunk_s;
    logic             diff_s, gt_s, fin_dec_s, fin_dir_s, finish_s;

    function automatic logic [CHUNK-1:0] chunk_of(input logic [WIDTH-1:0] v,
                                                   input logic [IDXW-1:0]  i);
        return v[i*CHUNK +: CHUNK];
    endfunction

    // Current-chunk comparison and end-of-compare decision.
    always_comb begin
        a_x_s     = sm_r ? (a_r ^ SIGN_MASK) : a_r;
        b_x_s     = sm_r ? (b_r ^ SIGN_MASK) : b_r;
        a_chunk_s = chunk_of(a_x_s, idx_r);
        b_chunk_s = chunk_of(b_x_s, idx_r);
        diff_s    = (a_chunk_s != b_chunk_s);
        gt_s      = (a_chunk_s > b_chunk_s);
        fin_dec_s = decided_r | diff_s;
        fin_dir_s = decided_r ? dir_r : gt_s;
`ifdef COMPARATOR_EARLY_EXIT_EN
        finish_s  = (idx_r == IDX_ZERO) || (diff_s && !decided_r);
`else
        finish_s  = (idx_r == IDX_ZERO);
`endif
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s   = state_r;
        a_s       = a_r;
        b_s       = b_r;
        sm_s      = sm_r;
        idx_s     = idx_r;
        decided_s = decided_r;
        dir_s     = dir_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        a_gt_s    = a_gt_r;
        b_gt_s    = b_gt_r;
        eq_s      = eq_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s   = BUSY;
                    a_s       = a;
                    b_s       = b;
                    sm_s      = signed_mode;
                    idx_s     = IDX_TOP;
                    decided_s = 1'b0;
                    dir_s     = 1'b0;
                    busy_s    = 1'b1;
                end else begin
                    state_s   = IDLE;
                    busy_s    = 1'b0;
                end
            end
            BUSY: begin
                if (!decided_r && diff_s) begin
                    decided_s = 1'b1;
                    dir_s     = gt_s;
                end else begin
                    decided_s = decided_r;
                end
                if (finish_s) begin
                    state_s = IDLE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    a_gt_s  = fin_dec_s & fin_dir_s;
                    b_gt_s  = fin_dec_s & ~fin_dir_s;
                    eq_s    = ~fin_dec_s;
                end else begin
                    idx_s   = idx_r - IDX_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            sm_r      <= 1'b0;
            idx_r     <= IDX_ZERO;
            decided_r <= 1'b0;
            dir_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            a_gt_r    <= 1'b0;
            b_gt_r    <= 1'b0;
            eq_r      <= 1'b0;
        end else begin
            state_r   <= state_s;
            a_r       <= a_s;
            b_r       <= b_s;
            sm_r      <= sm_s;
            idx_r     <= idx_s;
            decided_r <= decided_s;
            dir_r     <= dir_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            a_gt_r    <= a_gt_s;
            b_gt_r    <= b_gt_s;
            eq_r      <= eq_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign a_greater = a_gt_r;
    assign b_greater = b_gt_r;
    assign ab_equal  = eq_r;

endmodule

// File: tb/tb_seq_comparator.sv
// Directed scoreboard bench for seq_comparator (WIDTH=16, CHUNK=4); expected flags
// come from a reference magnitude compare and are queued when each start is driven.
module tb_seq_comparator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        signed_mode = 1'b0;
    logic        busy, done, a_greater, b_greater, ab_equal;

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    logic [2:0] sb[$];

    seq_comparator #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .signed_mode(signed_mode), .busy(busy), .done(done),
        .a_greater(a_greater), .b_greater(b_greater), .ab_equal(ab_equal)
    );

    always #5 clk = ~clk;

    // Count done pulses away from the active edge.
    always @(negedge clk) if (done) done_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result {a_greater, b_greater, ab_equal}.
    function automatic logic [2:0] model(input logic [15:0] x, input logic [15:0] y, input logic sm);
        if (sm) begin
            if ($signed(x) > $signed(y))      return 3'b100;
            else if ($signed(x) < $signed(y)) return 3'b010;
            else                              return 3'b001;
        end else begin
            if (x > y)      return 3'b100;
            else if (x < y) return 3'b010;
            else            return 3'b001;
        end
    endfunction

    // Edges from the accepting edge to the done edge.
    function automatic int lat(input logic [15:0] x, input logic [15:0] y);
        int k = 4;
        for (int i = 3; i >= 0; i--) begin
            if (k == 4 && x[i*4 +: 4] != y[i*4 +: 4]) k = 4 - i;
        end
`ifndef COMPARATOR_EARLY_EXIT_EN
        k = 4;
`endif
        return k;
    endfunction

    function automatic logic [2:0] flags();
        return {a_greater, b_greater, ab_equal};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmp(input logic [15:0] x, input logic [15:0] y, input logic sm);
        a = x; b = y; signed_mode = sm; start = 1'b1;
        sb.push_back(model(x, y, sm));
        tick();
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic finish_cmp(input int exp_lat, input int already);
        int edges = already;
        logic [2:0] exp;
        while (!done && edges <= 20) begin
            check("busy_while_running", {31'd0, busy}, 32'd1);
            tick();
            edges++;
        end
        check("latency", edges, exp_lat);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", sb.size(), 32'd1);
            exp = 3'b000;
        end else begin
            exp = sb.pop_front();
        end
        check("flags", {29'd0, flags()}, {29'd0, exp});
        tick();
        check("done_pulse_width", {31'd0, done}, 32'd0);
        check("flags_hold", {29'd0, flags()}, {29'd0, exp});
    endtask

    task automatic run_cmp(input logic [15:0] x, input logic [15:0] y, input logic sm);
        start_cmp(x, y, sm);
        finish_cmp(lat(x, y), 0);
    endtask

    logic [15:0] pa[4] = '{16'h1234, 16'h1235, 16'hABCD, 16'h0010};
    logic [15:0] pb[4] = '{16'h1234, 16'h1234, 16'hABCD, 16'h0020};

    initial begin
        int dc0;
        int edges;
        logic [2:0] exp;
        logic [2:0] prev;

        // Reset state
        tick(); tick();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_flags", {29'd0, flags()}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: equal operands
        run_cmp(16'h1234, 16'h1234, 1'b0);
        // 2: sign handling
        run_cmp(16'h8000, 16'h7FFF, 1'b0);
        run_cmp(16'h8000, 16'h7FFF, 1'b1);
        run_cmp(16'hFFFF, 16'h0001, 1'b1);
        run_cmp(16'h7FFF, 16'h7FFE, 1'b1);
        // 3: MSB-chunk difference vs LSB-chunk difference
        run_cmp(16'hF000, 16'h0000, 1'b0);
        run_cmp(16'h00F0, 16'h00F1, 1'b0);
        run_cmp(16'h0A00, 16'h0B00, 1'b0);

        // 4: start while busy is ignored
        dc0 = done_count;
        start_cmp(16'h0005, 16'h0003, 1'b0);
        tick();
        a = 16'h0001; b = 16'h0009; start = 1'b1;
        tick();
        start = 1'b0;
        finish_cmp(4, 2);
        repeat (6) tick();
        check("single_done_pulse", done_count - dc0, 32'd1);

        // 5: reset mid-operation
        dc0 = done_count;
        a = 16'h0001; b = 16'h0002; signed_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_flags", {29'd0, flags()}, 32'd0);
        rst = 1'b0;
        repeat (6) tick();
        check("no_done_after_reset", done_count - dc0, 32'd0);
        run_cmp(16'h0001, 16'h0002, 1'b0);

        // 6: start held high, alternating equal / unequal operands
        prev = 3'b010;
        a = pa[0]; b = pb[0]; signed_mode = 1'b0; start = 1'b1;
        sb.push_back(model(pa[0], pb[0], 1'b0));
        for (int i = 0; i < 4; i++) begin
            edges = 0;
            tick();
            edges++;
            check("held_flags_after_accept", {29'd0, flags()}, {29'd0, prev});
            while (!done && edges <= 20) begin
                tick();
                edges++;
            end
            check("back_to_back_period", edges, lat(pa[i], pb[i]) + 1);
            exp = (sb.size() > 0) ? sb.pop_front() : 3'b000;
            check("back_to_back_flags", {29'd0, flags()}, {29'd0, exp});
            prev = exp;
            if (i < 3) begin
                a = pa[i+1]; b = pb[i+1];
                sb.push_back(model(pa[i+1], pb[i+1], 1'b0));
            end else begin
                start = 1'b0;
            end
        end
        tick();
        check("final_idle", {31'd0, busy}, 32'd0);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
